// File: rtl/ddr2_wr_arbiter.sv
// Round-robin DDR2 write scheduler: two packed requesters share one command/data port.
// Each grant issues one command and then passes exactly BURST_LEN beats straight through.
module ddr2_wr_arbiter #(
  parameter int DW        = 64,
  parameter int AW        = 24,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          addr_load,
  input  logic          req0_avail,
  input  logic [DW-1:0] req0_data,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_base,
  input  logic [AW-1:0] req0_end,
  input  logic          req1_avail,
  input  logic [DW-1:0] req1_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_base,
  input  logic [AW-1:0] req1_end,
  output logic          cmd_en,
  output logic [AW-1:0] cmd_addr,
  input  logic          cmd_rdy,
  output logic [DW-1:0] wr_data,
  output logic          wr_data_en,
  input  logic          wr_data_rdy,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [1:0]    fsm_state
);

  // Handshake: a beat moves on every DATA cycle where the granted requester's
  // valid and wr_data_rdy are both high; the command moves when cmd_en & cmd_rdy.
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [AW-1:0] STEP      = AW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;

  state_t        state;
  logic [AW-1:0] ptr0;
  logic [AW-1:0] ptr1;
  logic [CW-1:0] beat_cnt;
  logic          last_grant;
  logic          load_pending;

  logic          in_data;
  logic          sel1;
  logic          beat;
  logic          load_now;
  logic          any_avail;
  logic          pick1;
  logic [AW-1:0] cur_ptr0;
  logic [AW-1:0] cur_ptr1;
  logic [AW-1:0] g_ptr;
  logic [AW-1:0] g_base;
  logic [AW-1:0] g_end;
  logic [AW-1:0] next_ptr;
  logic [AW-1:0] wrap_ptr;

  assign in_data    = (state == DATA);
  assign sel1       = grant[1];
  assign wr_data    = sel1 ? req1_data : req0_data;
  assign wr_data_en = in_data & (sel1 ? req1_valid : req0_valid);
  assign req0_ready = in_data & grant[0] & wr_data_rdy;
  assign req1_ready = in_data & grant[1] & wr_data_rdy;
  assign beat       = wr_data_en & wr_data_rdy;
  assign busy       = (state != IDLE);
  assign fsm_state  = state;

  // A pending reload must take effect before the grant picks its address.
  assign load_now  = addr_load | load_pending;
  assign cur_ptr0  = load_now ? req0_base : ptr0;
  assign cur_ptr1  = load_now ? req1_base : ptr1;
  assign any_avail = req0_avail | req1_avail;
  assign pick1     = (req0_avail & req1_avail) ? ~last_grant : req1_avail;

  assign g_ptr    = sel1 ? ptr1 : ptr0;
  assign g_base   = sel1 ? req1_base : req0_base;
  assign g_end    = sel1 ? req1_end : req0_end;
  assign next_ptr = g_ptr + STEP;
  assign wrap_ptr = (next_ptr >= g_end) ? g_base : next_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cmd_en       <= 1'b0;
      cmd_addr     <= '0;
      grant        <= 2'b00;
      ptr0         <= req0_base;
      ptr1         <= req1_base;
      beat_cnt     <= '0;
      last_grant   <= 1'b1;
      load_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_now) begin
            ptr0         <= req0_base;
            ptr1         <= req1_base;
            load_pending <= 1'b0;
          end
          if (any_avail) begin
            grant    <= pick1 ? 2'b10 : 2'b01;
            cmd_addr <= pick1 ? cur_ptr1 : cur_ptr0;
            cmd_en   <= 1'b1;
            state    <= CMD;
          end
        end
        CMD: begin
          if (addr_load) load_pending <= 1'b1;
          if (cmd_rdy) begin
            cmd_en   <= 1'b0;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (addr_load) load_pending <= 1'b1;
          if (beat) begin
            if (beat_cnt == LAST_BEAT) begin
              if (sel1) ptr1 <= wrap_ptr;
              else      ptr0 <= wrap_ptr;
              last_grant <= sel1;
              grant      <= 2'b00;
              state      <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_wr_arbiter.sv
// Bench for ddr2_wr_arbiter: a table of bursts (grant, address, stalls) plus a
// hand-written mid-burst reset; data beats are scoreboarded through exp_q.
module tb_ddr2_wr_arbiter;

  localparam int DW    = 64;
  localparam int AW    = 24;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          addr_load;
  logic          req0_avail, req1_avail;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_base, req0_end, req1_base, req1_end;
  logic          cmd_en;
  logic [AW-1:0] cmd_addr;
  logic          cmd_rdy;
  logic [DW-1:0] wr_data;
  logic          wr_data_en;
  logic          wr_data_rdy;
  logic [1:0]    grant;
  logic          busy;
  logic [1:0]    fsm_state;

  ddr2_wr_arbiter #(.DW(DW), .AW(AW), .BURST_LEN(BURST)) dut (
    .clk(clk), .reset(reset), .addr_load(addr_load),
    .req0_avail(req0_avail), .req0_data(req0_data), .req0_valid(req0_valid),
    .req0_ready(req0_ready), .req0_base(req0_base), .req0_end(req0_end),
    .req1_avail(req1_avail), .req1_data(req1_data), .req1_valid(req1_valid),
    .req1_ready(req1_ready), .req1_base(req1_base), .req1_end(req1_end),
    .cmd_en(cmd_en), .cmd_addr(cmd_addr), .cmd_rdy(cmd_rdy),
    .wr_data(wr_data), .wr_data_en(wr_data_en), .wr_data_rdy(wr_data_rdy),
    .grant(grant), .busy(busy), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic          in_data = 1'b0;
  logic [31:0]   word_ctr = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the oldest word offered.
  always @(negedge clk) begin
    if (in_data) begin
      if (wr_data_en && wr_data_rdy) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else check("wr_data", wr_data, exp_q.pop_front());
      end
      check("other_ready", (grant == 2'b10) ? req0_ready : req1_ready, 64'd0);
      check("granted_ready", (grant == 2'b10) ? req1_ready : req0_ready, wr_data_rdy);
      check("wr_data_en", wr_data_en, (grant == 2'b10) ? req1_valid : req0_valid);
    end
  end

  // Driver: one full grant. Returns at posedge+1 once nbeats beats are offered.
  task automatic burst(input logic [1:0] g, input logic [AW-1:0] addr, input int cmd_wait,
                       input bit stall, input bit load, input int nbeats);
    bit            found;
    bit            s1;
    bit            v, r;
    int            n, cyc;
    logic [DW-1:0] word;
    s1 = (g == 2'b10);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = cmd_en;
    end
    check("cmd_seen", found, 1'b1);
    if (!found) return;
    check("grant", grant, g);
    check("cmd_addr", cmd_addr, addr);
    check("busy_cmd", busy, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1; wr_data_rdy = 1'b1;
    for (int i = 0; i < cmd_wait; i++) begin
      @(negedge clk);
      check("cmd_en_hold", cmd_en, 1'b1);
      check("cmd_addr_hold", cmd_addr, addr);
      check("cmd_no_ready", {req0_ready, req1_ready, wr_data_en}, 3'b000);
      @(posedge clk); #1;
    end
    cmd_rdy = 1'b1;
    @(negedge clk);
    check("cmd_accept_en", cmd_en, 1'b1);
    check("cmd_accept_no_ready", {req0_ready, req1_ready, wr_data_en}, 3'b000);
    @(posedge clk); #1;
    cmd_rdy = 1'b0;
    in_data = 1'b1;
    n = 0;
    cyc = 0;
    while (n < nbeats && cyc < 60) begin
      v = stall ? !(cyc == 2 || cyc == 3) : 1'b1;
      r = stall ? (cyc % 2 == 0) : 1'b1;
      word = {4'(s1 ? 2 : 1), 28'h0, word_ctr};
      if (s1) begin
        req1_valid = v; req1_data = word; req0_valid = !v; req0_data = ~word;
      end else begin
        req0_valid = v; req0_data = word; req1_valid = !v; req1_data = ~word;
      end
      wr_data_rdy = r;
      addr_load = load && (cyc == 1);
      if (v && r) begin
        exp_q.push_back(word);
        n++;
        word_ctr++;
      end
      @(negedge clk);
      if (cyc == 0) check("cmd_en_drop", cmd_en, 1'b0);
      check("grant_data", grant, g);
      check("busy_data", busy, 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    check("beats_done", n, nbeats);
    in_data = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; wr_data_rdy = 1'b0; addr_load = 1'b0;
    if (nbeats == BURST) begin
      check("queue_empty", exp_q.size(), 0);
      @(negedge clk);
      check("idle_grant", grant, 2'b00);
      check("idle_busy", busy, 1'b0);
      check("idle_cmd_en", cmd_en, 1'b0);
    end
  endtask

  typedef struct {
    bit          a0;
    bit          a1;
    logic [1:0]  g;
    logic [AW-1:0] addr;
    int          cmd_wait;
    bit          stall;
    bit          load;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Regions: req0 holds four bursts, req1 holds two.
    vecs[0]  = '{1'b1, 1'b1, 2'b01, 24'h100, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 24'h200, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 2'b01, 24'h104, 0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 2'b10, 24'h204, 0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 24'h108, 0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, 24'h10C, 0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 24'h100, 0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 2'b10, 24'h200, 5, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 24'h104, 0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 24'h108, 0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'b10, 24'h204, 0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 2'b01, 24'h100, 0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 2'b10, 24'h200, 0, 1'b0, 1'b0};

    reset = 1'b0; addr_load = 1'b0; cmd_rdy = 1'b0; wr_data_rdy = 1'b0;
    req0_avail = 1'b0; req1_avail = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    req0_base = 24'h100; req0_end = 24'h110;
    req1_base = 24'h200; req1_end = 24'h208;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_en", cmd_en, 1'b0);
    check("rst_cmd_addr", cmd_addr, 24'h0);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_state", fsm_state, 2'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int k = 0; k < 13; k++) begin
      req0_avail = vecs[k].a0;
      req1_avail = vecs[k].a1;
      burst(vecs[k].g, vecs[k].addr, vecs[k].cmd_wait, vecs[k].stall, vecs[k].load, BURST);
    end

    // Mid-burst reset after two beats: pointer must not advance.
    req0_avail = 1'b1; req1_avail = 1'b0;
    burst(2'b01, 24'h104, 0, 1'b0, 1'b0, 2);
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; req0_avail = 1'b0;
    req0_valid = 1'b1; wr_data_rdy = 1'b1;
    @(negedge clk);
    check("abort_cmd_en", cmd_en, 1'b0);
    check("abort_cmd_addr", cmd_addr, 24'h0);
    check("abort_grant", grant, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_state", fsm_state, 2'd0);
    check("abort_outs", {wr_data_en, req0_ready, req1_ready}, 3'b000);
    req0_valid = 1'b0; wr_data_rdy = 1'b0;
    req0_avail = 1'b1; req1_avail = 1'b1;
    burst(2'b01, 24'h100, 0, 1'b0, 1'b0, BURST);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/ddr2_wr_arbiter.md
Name: ddr2_wr_arbiter

Overview:
- Round-robin write scheduler sharing the DDR2 write port between two packed-data requesters. Each requester is a 64-bit packed stream fed from an upstream packer/FIFO.
- Each grant issues one write command, then transfers exactly BURST_LEN data beats from the granted requester.
- Keeps a per-requester circular address pointer inside a programmable region. Sits between the packer/FIFO stage and the DDR2 controller user interface.

Parameters:
- DW, 64, data width of requester streams and wr_data.
- AW, 24, DDR2 word address width.
- BURST_LEN, 4, beats per grant; power of two, 2..16.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-low reset.
- addr_load  in  1  one-cycle pulse; reload both pointers from their base addresses.
- req0_avail  in  1  requester 0 holds at least BURST_LEN words.
- req0_data  in  DW  requester 0 data.
- req0_valid  in  1  requester 0 data valid.
- req0_ready  out  1  requester 0 beat accepted.
- req0_base  in  AW  requester 0 region start (inclusive).
- req0_end  in  AW  requester 0 region end (exclusive).
- req1_avail, req1_data, req1_valid, req1_ready, req1_base, req1_end: same as requester 0.
- cmd_en  out  1  write command request.
- cmd_addr  out  AW  burst start address.
- cmd_rdy  in  1  controller accepts command.
- wr_data  out  DW  write data.
- wr_data_en  out  1  write data valid.
- wr_data_rdy  in  1  controller accepts data.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (reset=0 at a clk edge) forces:
  - state=IDLE; cmd_en=0, cmd_addr=0, grant=00, busy=0, wr_data_en=0, req*_ready=0.
  - ptr0=req0_base, ptr1=req1_base, beat counter=0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset mid-burst aborts the burst. No further beats are accepted and the pointer is not advanced.
- FSM states: IDLE, CMD, DATA.
- IDLE:
  - Only req0_avail=1: grant requester 0.
  - Only req1_avail=1: grant requester 1.
  - Both: grant the one that is not last_grant.
  - On any grant: register grant, load cmd_addr from ptr[g], go to CMD next cycle.
  - Neither avail: stay in IDLE.
- CMD:
  - cmd_en=1; cmd_addr and grant are held stable until cmd_rdy=1.
  - On the cycle with cmd_en&cmd_rdy: go to DATA, beat counter=0.
  - cmd_en deasserts the following cycle.
- DATA (combinational pass-through, zero latency):
  - wr_data = reqg_data.
  - wr_data_en = reqg_valid.
  - reqg_ready = wr_data_rdy.
  - The non-granted requester's ready stays 0.
  - One beat is transferred on each cycle with reqg_valid & wr_data_rdy; the beat counter increments on each beat.
  - On the beat where counter=BURST_LEN-1:
    - next = ptr[g]+BURST_LEN;
    - ptr[g] = base[g] if next >= end[g], else next;
    - last_grant=g; go to IDLE; grant=00.
- IDLE→CMD takes one cycle. Back-to-back bursts therefore have at least one IDLE cycle between the last beat and the next cmd_en.
- reqN_avail is sampled only in IDLE. Deassertion during CMD/DATA is ignored; valid/ready governs the beats.
- addr_load:
  - Takes effect only in IDLE. Pulses arriving in CMD/DATA are held pending and applied on the next IDLE cycle, before the grant decision.
  - Base/end inputs must be stable while busy=1.
- Region rules: end-base must be a non-zero multiple of BURST_LEN. Address arithmetic is AW-bit unsigned; ptr+BURST_LEN overflow wraps modulo 2^AW and is then compared.
- Stalls: wr_data_rdy=0 or reqg_valid=0 in DATA simply holds the state. There is no timeout.

Test Plan:
- Single requester: req0_base=0x100, req0_end=0x110, BURST_LEN=4, req0_avail held, 4 bursts → cmd_addr 0x100, 0x104, 0x108, 0x10C. The 5th burst goes to 0x100; 4 wr_data_en beats per burst; grant=01.
- Both avail continuously → grant alternates 01, 10, 01, 10 starting with requester 0. req1_ready stays 0 throughout requester 0 bursts.
- cmd_rdy held low 5 cycles → cmd_en stays 1 and cmd_addr stays constant. No req*_ready until the cycle after cmd_rdy=1.
- DATA backpressure: toggle wr_data_rdy 1,0,1,0 and drop req0_valid for 2 cycles mid-burst → exactly 4 beats pass with data order preserved, and ptr advances only after the 4th beat.
- addr_load pulsed during requester 1's DATA phase → the current burst completes, and the next bursts from both requesters start at their bases.
- reset=0 for one cycle after 2 of 4 beats → all outputs return to reset values; ptr0 is back at base. The next burst starts at req0_base with grant=01.
